// File: rtl/iic_slave_regs.sv
// I2C target with a single 7-bit address and an 8-bit register-pointer port.
// SCL/SDA are oversampled on clk; writes become wr_en strobes, reads are fetched via rd_req/rd_data.
module iic_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h68,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_en,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_req,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       addressed
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK, S_WRITE,
    S_WRITE_ACK, S_READ, S_READ_ACK, S_WAIT, S_IGNORE
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_d, sda_d;
  logic                   scl, sda;
  logic                   scl_rise, scl_fall, start_cond, stop_cond;

  logic [7:0] shift_reg;
  logic [3:0] bit_cnt;
  logic [7:0] ptr;
  logic       load_pending;
  logic       nack_q;
  logic       byte_done, addr_match, rw;

  // NOTE: synchronizers reset to the idle bus level (high) so releasing
  // reset cannot manufacture a START or STOP out of the flop reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl      = scl_sync[SYNC_STAGES-1];
  assign sda      = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl & ~scl_d;
  assign scl_fall = ~scl & scl_d;
  // SCL must be high in both samples, so a coincident SCL/SDA edge is data.
  assign start_cond = scl & scl_d & sda_d & ~sda;
  assign stop_cond  = scl & scl_d & ~sda_d & sda;

  assign byte_done  = (bit_cnt == 4'd8);
  assign addr_match = (shift_reg[7:1] == SLAVE_ADDR);
  assign rw         = shift_reg[0];
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // NOTE: next state takes a default before any branch so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    if (start_cond) begin
      state_next = S_ADDR;
    end else if (stop_cond) begin
      state_next = S_IDLE;
    end else if (scl_fall) begin
      unique case (state)
        S_ADDR:      if (byte_done) state_next = addr_match ? S_ADDR_ACK : S_IGNORE;
        S_ADDR_ACK:  state_next = rw ? S_READ : S_REG;
        S_REG:       if (byte_done) state_next = S_REG_ACK;
        S_REG_ACK:   state_next = S_WRITE;
        S_WRITE:     if (byte_done) state_next = S_WRITE_ACK;
        S_WRITE_ACK: state_next = S_WRITE;
        S_READ:      if (byte_done) state_next = S_READ_ACK;
        S_READ_ACK:  state_next = nack_q ? S_WAIT : S_READ;
        default:     state_next = state;
      endcase
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_en       <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      rd_req       <= 1'b0;
      rd_addr      <= '0;
      addressed    <= 1'b0;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      ptr          <= '0;
      load_pending <= 1'b0;
      nack_q       <= 1'b0;
    end else begin
      wr_en        <= 1'b0;
      rd_req       <= 1'b0;
      load_pending <= 1'b0;
      if (start_cond || stop_cond) begin
        bit_cnt   <= '0;
        sda_en    <= 1'b0;
        addressed <= 1'b0;
      end else begin
        // Read data arrives one clk after rd_req; present its MSB right away.
        if (load_pending) begin
          shift_reg <= rd_data;
          sda_en    <= ~rd_data[7];
        end
        if (scl_rise) begin
          case (state)
            S_ADDR, S_REG, S_WRITE: begin
              shift_reg <= {shift_reg[6:0], sda};
              bit_cnt   <= bit_cnt + 4'd1;
            end
            S_READ: bit_cnt <= bit_cnt + 4'd1;
            S_WRITE_ACK: begin
              wr_en   <= 1'b1;
              wr_addr <= ptr;
              wr_data <= shift_reg;
              ptr     <= ptr + 8'd1;
            end
            S_READ_ACK: begin
              nack_q <= sda;
              if (!sda) ptr <= ptr + 8'd1;
            end
            default: ;
          endcase
        end
        if (scl_fall) begin
          case (state)
            S_ADDR: if (byte_done) begin
              bit_cnt <= '0;
              if (addr_match) begin
                sda_en    <= 1'b1;
                addressed <= 1'b1;
              end
            end
            S_ADDR_ACK: begin
              sda_en  <= 1'b0;
              bit_cnt <= '0;
              if (rw) begin
                rd_req       <= 1'b1;
                rd_addr      <= ptr;
                load_pending <= 1'b1;
              end
            end
            S_REG: if (byte_done) begin
              ptr     <= shift_reg;
              sda_en  <= 1'b1;
              bit_cnt <= '0;
            end
            S_WRITE: if (byte_done) begin
              sda_en  <= 1'b1;
              bit_cnt <= '0;
            end
            S_REG_ACK, S_WRITE_ACK: begin
              sda_en  <= 1'b0;
              bit_cnt <= '0;
            end
            S_READ: begin
              if (byte_done) begin
                sda_en  <= 1'b0;
                bit_cnt <= '0;
              end else begin
                sda_en    <= ~shift_reg[6];
                shift_reg <= {shift_reg[6:0], 1'b0};
              end
            end
            S_READ_ACK: begin
              bit_cnt <= '0;
              if (!nack_q) begin
                rd_req       <= 1'b1;
                rd_addr      <= ptr;
                load_pending <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_iic_slave_regs.sv
// Bus-master bench for iic_slave_regs: directed scenarios plus random write/read-back
// transactions checked against a transaction-level register-file model.
`timescale 1ns/1ps
module tb_iic_slave_regs;

  localparam int         Q   = 10;      // clk cycles per quarter SCL period
  localparam logic [6:0] DEV = 7'h68;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_en, wr_en, rd_req, busy, addressed;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
  wire        sda_line = sda_m & ~sda_en;

  logic [7:0]  regs [256];
  logic [7:0]  model_mem [256];
  logic [7:0]  model_ptr;
  logic [15:0] wr_log[$], exp_wr[$];
  logic [7:0]  rd_log[$], exp_rd[$];
  bit          sda_seen;
  int          n_checks = 0;
  int          n_pass = 0;

  always #10 clk = ~clk;

  assign rd_data = regs[rd_addr];

  iic_slave_regs #(.SLAVE_ADDR(DEV), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl_m), .sda_in(sda_line),
    .sda_en(sda_en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .addressed(addressed)
  );

  always @(posedge clk) begin
    if (wr_en) begin
      regs[wr_addr] <= wr_data;
      wr_log.push_back({wr_addr, wr_data});
    end
    if (rd_req) rd_log.push_back(rd_addr);
    if (sda_en) sda_seen = 1'b1;
  end

  initial begin
    #1600us;
    $display("FAIL watchdog: run did not finish (observed timeout, required completion)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- bus master primitives ----------------
  task automatic hold();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();   // also serves as repeated START from SCL low
    sda_m = 1'b1; hold();
    scl_m = 1'b1; hold();
    sda_m = 1'b0; hold();
    scl_m = 1'b0; hold();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; hold();
    scl_m = 1'b1; hold();
    sda_m = 1'b1; hold(); hold();
  endtask

  task automatic put_bit(input logic b);
    sda_m = b;    hold();
    scl_m = 1'b1; hold(); hold();
    scl_m = 1'b0; hold();
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; hold();
    scl_m = 1'b1; hold();
    b = sda_line; hold();
    scl_m = 1'b0; hold();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(nack);
  endtask

  // ---------------- transactions with model update ----------------
  task automatic do_write(input logic [7:0] p, input logic [7:0] d[$], input string tag);
    logic ack;
    bus_start();
    write_byte({DEV, 1'b0}, ack); check({tag, "_addr_ack"}, ack, 0);
    write_byte(p, ack);           check({tag, "_ptr_ack"}, ack, 0);
    model_ptr = p;
    foreach (d[i]) begin
      write_byte(d[i], ack);
      check($sformatf("%s_data_ack%0d", tag, i), ack, 0);
      model_mem[model_ptr] = d[i];
      exp_wr.push_back({model_ptr, d[i]});
      model_ptr = model_ptr + 8'd1;
    end
    bus_stop();
  endtask

  // Reads n bytes, ACKing all but the last; optionally sets the pointer first via Sr.
  task automatic do_read(input bit set_ptr, input logic [7:0] p, input int n, input string tag);
    logic ack;
    logic [7:0] d;
    bus_start();
    if (set_ptr) begin
      write_byte({DEV, 1'b0}, ack); check({tag, "_waddr_ack"}, ack, 0);
      write_byte(p, ack);           check({tag, "_ptr_ack"}, ack, 0);
      model_ptr = p;
      bus_start();
    end
    write_byte({DEV, 1'b1}, ack); check({tag, "_raddr_ack"}, ack, 0);
    for (int k = 0; k < n; k++) begin
      read_byte(k == n - 1, d);
      check($sformatf("%s_byte%0d", tag, k), d, model_mem[model_ptr]);
      exp_rd.push_back(model_ptr);
      if (k != n - 1) model_ptr = model_ptr + 8'd1;
    end
    check({tag, "_sda_released"}, sda_en, 0);
    bus_stop();
  endtask

  task automatic check_logs(input string tag);
    check({tag, "_wr_count"}, wr_log.size(), exp_wr.size());
    for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), wr_log[i], exp_wr[i]);
    check({tag, "_rd_count"}, rd_log.size(), exp_rd.size());
    for (int i = 0; i < rd_log.size() && i < exp_rd.size(); i++)
      check($sformatf("%s_rd%0d", tag, i), rd_log[i], exp_rd[i]);
    wr_log.delete(); exp_wr.delete(); rd_log.delete(); exp_rd.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sda_en"}, sda_en, 0);
    check({tag, "_strobes"}, {wr_en, rd_req, busy, addressed}, 0);
    check({tag, "_wr_bus"}, {wr_addr, wr_data}, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
  endtask

  initial begin
    logic [7:0] dq[$];
    logic ack;

    for (int i = 0; i < 256; i++) begin
      regs[i]      = 8'(i);
      model_mem[i] = 8'(i);
    end
    model_ptr = 8'h00;

    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    hold();

    // Plain write of two bytes; then a current-pointer read shows the pointer at 0x6D.
    dq = {8'h00, 8'h01};
    do_write(8'h6B, dq, "t1");
    check("t1_busy_after_stop", busy, 0);
    do_read(1'b0, 8'h00, 1, "t1_cur");
    check("t1_ptr_end", exp_rd[0], 8'h6D);
    check_logs("t1");

    // Pointer write, repeated START, single-byte read with master NACK.
    regs[8'h75] = 8'h68; model_mem[8'h75] = 8'h68;
    do_read(1'b1, 8'h75, 1, "t2");
    check_logs("t2");

    // Burst read across the pointer wrap.
    do_read(1'b1, 8'hFE, 3, "t3");
    check_logs("t3");

    // Foreign address: never ACKed, never driven, bus still reported busy.
    sda_seen = 1'b0;
    bus_start();
    write_byte({7'h69, 1'b0}, ack); check("t4_addr_nack", ack, 1);
    check("t4_busy_addressed", {busy, addressed}, 2'b10);
    write_byte(8'hAA, ack);         check("t4_data_nack", ack, 1);
    bus_stop();
    check("t4_busy_after_stop", busy, 0);
    check("t4_sda_never_driven", sda_seen, 0);
    check_logs("t4");

    // STOP four bits into a data byte, then a fresh transaction.
    bus_start();
    write_byte({DEV, 1'b0}, ack); check("t5_addr_ack", ack, 0);
    write_byte(8'h10, ack);       check("t5_ptr_ack", ack, 0);
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
    bus_stop();
    dq = {8'h55};
    do_write(8'h20, dq, "t5b");
    check_logs("t5");

    // Asynchronous reset while the address ACK is being driven.
    bus_start();
    for (int i = 7; i >= 0; i--) put_bit(DEV_W_BIT(i));
    check("t6_ack_driven", sda_en, 1);
    #3 rst_n = 1'b0;
    #1 check("t6_async_release", sda_en, 0);
    repeat (3) @(negedge clk);
    check_reset_outputs("t6_reset");
    model_ptr = 8'h00;
    rst_n = 1'b1;
    sda_m = 1'b1; hold();
    scl_m = 1'b1; hold();
    do_read(1'b0, 8'h00, 1, "t6_ptr0");
    dq = {8'h99, 8'h3C};
    do_write(8'h40, dq, "t6_wr");
    check_logs("t6");

    // Random write bursts each read back one byte past the end.
    for (int it = 0; it < 5; it++) begin
      logic [7:0] p;
      int nw;
      p  = 8'($urandom);
      nw = $urandom_range(1, 3);
      dq.delete();
      for (int j = 0; j < nw; j++) dq.push_back(8'($urandom));
      do_write(p, dq, $sformatf("rnd%0d_wr", it));
      do_read(1'b1, p, nw + 1, $sformatf("rnd%0d_rd", it));
      check_logs($sformatf("rnd%0d", it));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  function automatic logic DEV_W_BIT(input int i);
    logic [7:0] b;
    b = {DEV, 1'b0};
    return b[i];
  endfunction

endmodule

// File: doc/iic_slave_regs.md
# iic_slave_regs

Standard-mode/fast-mode I2C target (slave) that responds to a single 7-bit device address and exposes an 8-bit register-pointer interface to local logic. It oversamples SCL/SDA on the system clock, decodes START/STOP/repeated-START, ACKs matching transactions, and converts bus writes into one-cycle register write strobes. Bus reads are served from a registered read port. It sits at the far end of the I2C bus from the team's I2C master. It serves as the on-chip target for loopback tests and as an MPU-6050-style register stand-in.

## Interface
- SLAVE_ADDR, 7'h68, 7-bit device address this target answers to
- SYNC_STAGES, 2, synchronizer depth for scl_in/sda_in (min 2)
- clk  in  1  system clock, ≥ 20× SCL frequency (50 MHz nominal)
- rst_n  in  1  reset, asynchronous, active-low
- scl_in  in  1  bus SCL level (asynchronous)
- sda_in  in  1  bus SDA level (asynchronous)
- sda_en  out  1  1 = pull SDA low (open-drain); 0 = release
- wr_en  out  1  one-cycle write strobe
- wr_addr  out  8  register address for wr_en
- wr_data  out  8  write data for wr_en
- rd_req  out  1  one-cycle pulse; rd_data must be valid on the next clk
- rd_addr  out  8  register address being read, valid with rd_req
- rd_data  in  8  read data, sampled 1 clk after rd_req
- busy  out  1  high from START through STOP, addressed or not
- addressed  out  1  high from address ACK until STOP/START

## Operation
- Input path: SYNC_STAGES-flop synchronizer on each line, plus one delay flop used for edge detection. All decisions use the synchronized/delayed values.
- START: synchronized SDA falls while SCL high. STOP: SDA rises while SCL high. Both are recognized in any state, including mid-byte.
- On START or repeated START:
  - clear bit counter and release sda_en;
  - go to ADDR;
  - keep the register pointer.
- On STOP: go to IDLE, release sda_en, clear busy and addressed.
- Data bits are sampled on the SCL rising edge, MSB first. sda_en changes only on the SCL falling edge.
- States and transitions:
  - IDLE: wait for START.
  - ADDR: shift in 8 bits. If [7:1]==SLAVE_ADDR, go to ADDR_ACK; otherwise go to IGNORE until the next START/STOP.
  - ADDR_ACK: drive sda_en=1 for the 9th SCL period.
    - R/W=0 → REG.
    - R/W=1 → READ.
  - REG: shift 8 bits into the pointer, then REG_ACK (ACK) → WRITE.
  - WRITE: shift 8 bits, then WRITE_ACK (ACK). On that ACK's SCL rising edge, pulse wr_en with wr_addr=pointer and wr_data=byte, then increment the pointer → WRITE.
  - READ:
    - On the falling edge that enters READ, pulse rd_req with rd_addr=pointer. Latch rd_data into the shift register 1 clk later.
    - Present bits via sda_en=~bit on each falling edge.
    - After bit 0, release SDA → READ_ACK.
  - READ_ACK: sample master ACK on the rising edge.
    - ACK (0): increment the pointer, then READ.
    - NACK (1): go to WAIT (SDA released) until START/STOP.
- Pointer arithmetic: 8-bit, wraps 0xFF→0x00.
- No clock stretching. A master NACK ends the read.

## Timing
- Reset values:
  - outputs: sda_en=0, wr_en=0, wr_addr=0, wr_data=0, rd_req=0, rd_addr=0, busy=0, addressed=0;
  - internal state: pointer=0, state=IDLE.
- Bus-to-decision latency: SYNC_STAGES+1 clk after a pin edge (3 clk at default). SDA output changes ≤ 4 clk after the SCL pin falls, which satisfies tHD;DAT at 400 kHz/50 MHz.
- wr_en: exactly one clk per written byte. A byte aborted by START/STOP before its ACK produces no wr_en.
- rd_req: exactly one clk per byte transmitted, including the first byte after a read address.
- Asynchronous rst_n mid-transfer releases SDA immediately. The next transaction is recognized only after a fresh START.
- Simultaneous SCL and SDA edges in the same synchronized sample are treated as a data change, not START/STOP.

## Test plan
- Write 0x68+W, ptr 0x6B, data 0x00, 0x01, STOP → ACK on all 4 bytes. wr_en pulses (0x6B,0x00) and (0x6C,0x01). Pointer ends at 0x6D.
- Write 0x68+W, ptr 0x75, Sr, 0x68+R with rd_data=0x68, master NACK, STOP → rd_req with rd_addr=0x75. Master reads 0x68. sda_en=0 after byte.
- Burst read of 3 bytes starting at ptr 0xFE with rd_data=rd_addr → bytes 0xFE, 0xFF, 0x00 (pointer wraps).
- Address 0x69+W, data 0xAA → SDA never driven, wr_en never asserts, addressed=0, busy=1 until STOP.
- STOP after 4 data bits of a write, then a new START → no wr_en, and the new address is decoded correctly.
- rst_n low while sda_en=1 during an ACK → sda_en=0 asynchronously. All outputs return to reset values. A subsequent full write completes.
